// File: rtl/onchip_stream_pkg.sv
// Shared constants, FSM state and FIFO entry type for the on-chip RAM stream reader.
package onchip_stream_pkg;

  localparam int unsigned MEM_WORDS = 32000;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } fifo_entry_t;

  // The RAM is not a power-of-two deep, so the address wraps at MEM_WORDS, not 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
    return (addr == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with flush; storage is unreset, only pointers and count are.
module stream_fifo #(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   pop_data,
  output logic [$clog2(Depth):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(Depth);

  entry_t          mem [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PtrW + 1)'(Depth));
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/onchip_stream_reader.sv
// Avalon-MM read master streaming a window of on-chip RAM out as Avalon-ST,
// with credit-based issue so the output FIFO can never overflow.
module onchip_stream_reader
  import onchip_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic              loop_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       issue_cnt_q, issue_cnt_d;
  logic              loop_q, loop_d;
  logic              in_flight_q;
  logic              tag_sop_q, tag_eop_q;
  logic              done_q, done_d;

  logic              issue, last_issue, credit_ok, flush, pop;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     occupancy;
  logic              fifo_empty, fifo_full;
  fifo_entry_t       push_entry, head;

  assign occupancy  = {1'b0, fifo_count} + (CntW + 1)'(in_flight_q);
  assign credit_ok  = (occupancy < (CntW + 1)'(FIFO_DEPTH)) && !fifo_full;
  assign last_issue = (issue_cnt_q == len_q - 16'd1);
  assign flush      = abort && (state_q != IDLE);
  assign pop        = !fifo_empty && src_ready;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    base_d      = base_q;
    len_d       = len_q;
    loop_d      = loop_q;
    issue_cnt_d = issue_cnt_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort && (length != 16'd0)) begin
          base_d      = base_addr;
          cur_addr_d  = base_addr;
          len_d       = length;
          loop_d      = loop_en;
          issue_cnt_d = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (last_issue) begin
            if (loop_q) begin
              // Reload in the same cycle so the next pass issues without a bubble.
              cur_addr_d  = base_q;
              issue_cnt_d = '0;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            cur_addr_d  = next_addr(cur_addr_q);
            issue_cnt_d = issue_cnt_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!in_flight_q &&
                     (fifo_empty || ((fifo_count == CntW'(1)) && pop))) begin
          // Leave as the last word pops so done and busy-low land on the next cycle.
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      base_q      <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      issue_cnt_q <= '0;
      in_flight_q <= 1'b0;
      tag_sop_q   <= 1'b0;
      tag_eop_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      base_q      <= base_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      issue_cnt_q <= issue_cnt_d;
      in_flight_q <= issue;
      if (issue) begin
        tag_sop_q <= (issue_cnt_q == 16'd0);
        tag_eop_q <= last_issue;
      end
      done_q <= done_d;
    end
  end

  assign push_entry.data = mem_readdata;
  assign push_entry.sop  = tag_sop_q;
  assign push_entry.eop  = tag_eop_q;

  stream_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_flight_q),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign mem_chipselect = issue;
  assign mem_address    = issue ? cur_addr_q : '0;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign src_valid      = !fifo_empty;
  assign src_data       = fifo_empty ? '0 : head.data;
  assign src_sop        = !fifo_empty && head.sop;
  assign src_eop        = !fifo_empty && head.eop;

endmodule

// File: doc/onchip_stream_reader.md
Name: onchip_stream_reader

Overview:
- Avalon-MM read master sitting directly upstream of the 32000x32 single-port on-chip RAM.
- Streams a programmed window of words out of the RAM as an Avalon-ST source feeding the DSP datapath.
- Absorbs the RAM's fixed 1-cycle read latency and downstream backpressure with a credit-controlled output FIFO.
- Supports one-shot or continuous loop playback, with address wrap at the RAM's word depth.

Parameters:
- MEM_WORDS, 32000: RAM depth in words; addresses wrap from MEM_WORDS-1 to 0.
- ADDR_W, 15: RAM word-address width.
- DATA_W, 32: word width.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a transfer
- abort  in  1  one-cycle request to cancel the transfer in progress
- base_addr  in  ADDR_W  first word address; must be less than MEM_WORDS
- length  in  16  words per pass, 1..MEM_WORDS
- loop_en  in  1  repeat the pass until abort
- busy  out  1  transfer active (RUN or DRAIN)
- done  out  1  one-cycle pulse when a non-loop transfer completes
- mem_address  out  ADDR_W  RAM word address
- mem_chipselect  out  1  read strobe; high exactly on issue cycles
- mem_write  out  1  tied 0
- mem_byteenable  out  4  tied 4'hF
- mem_clken  out  1  tied 1
- mem_readdata  in  DATA_W  RAM read data, valid the cycle after issue
- src_data  out  DATA_W  stream data
- src_valid  out  1  stream valid
- src_ready  in  1  stream ready
- src_sop  out  1  first word of a pass
- src_eop  out  1  last word of a pass

Behaviour:
- Reset (async assert, sync release): state IDLE; FIFO empty; all counters 0. Outputs: busy=0, done=0, mem_chipselect=0, mem_address=0, src_valid=0, src_sop=0, src_eop=0.
- IDLE:
  - start=1 with length!=0: latch base_addr, length, loop_en; go to RUN.
  - start=1 with length=0: ignored; stays IDLE, no done.
- RUN:
  - Issue a read (mem_chipselect=1, mem_address=cur_addr) when in_flight + fifo_count < FIFO_DEPTH.
  - in_flight is 0 or 1. The returned word is written into the FIFO the cycle after issue, together with its sop/eop tags.
  - cur_addr increments per issue and wraps MEM_WORDS-1 -> 0, never 2^ADDR_W.
  - When the issue count reaches the latched length:
    - Loop mode: cur_addr reloads the latched base and the count clears (no bubble cycle); continue RUN.
    - Otherwise: go to DRAIN.
- DRAIN: no issues. When in_flight=0 and the FIFO is empty: go to IDLE, pulse done for 1 cycle, busy falls the same cycle.
- Stream handshake:
  - src_valid = FIFO not empty.
  - A word pops on src_valid & src_ready.
  - src_data, src_sop and src_eop are held stable while src_valid=1 and src_ready=0.
  - length=1 gives sop=eop=1 on the same word.
- Latency: start at cycle 0 -> first issue at cycle 1 -> data captured at cycle 2 -> src_valid=1 at cycle 3.
- Throughput: with src_ready held 1, one word per cycle sustained, including across loop boundaries.
- abort (any state except IDLE):
  - Next cycle: state IDLE, FIFO flushed, any in-flight return discarded, busy=0, src_valid=0, no done pulse.
  - abort in IDLE has no effect.
  - abort and start in the same cycle: abort wins.
- start while busy: ignored. Latched parameters are frozen during a transfer.
- Simultaneous FIFO push and pop: fifo_count is unchanged.

Decomposition:
- Package onchip_stream_pkg holds:
  - constants MEM_WORDS, ADDR_W, DATA_W;
  - enum state_t {IDLE, RUN, DRAIN};
  - struct fifo_entry_t {data, sop, eop}.
- One sub-module, stream_fifo: synchronous FIFO parameterised by depth and entry type, with push, pop, flush, count, empty and full.
- Top level contains the FSM, address/issue counters, in-flight flag and credit check.

Test Plan:
- One-shot, base=100, length=8, src_ready=1: addresses 100..107 issued on 8 consecutive cycles; data matches RAM; sop on word 0, eop on word 7; done pulses 1 cycle after the last pop; busy low the same cycle.
- Wrap, base=31998, length=4: addresses 31998, 31999, 0, 1 issued; never 32000.
- Backpressure, length=16, src_ready toggling 1,0,0,1,...: no lost or duplicated words; data held stable while stalled; fifo_count never exceeds 4; issues stall while FIFO plus in-flight equals 4.
- Loop, base=0, length=3, loop_en=1: stream 0,1,2,0,1,2,... at 1 word/cycle with sop on every word at address 0 and eop on every word at address 2; abort mid-pass -> src_valid=0 and busy=0 next cycle; no done.
- Edge requests: length=0 start -> busy stays 0; length=1 -> single word with sop=eop=1; start while busy ignored; abort and start in the same cycle -> IDLE.
- Async reset asserted mid-transfer: all outputs 0 immediately; after release, a fresh base=5, length=2 start yields the correct two words.
